imm_encoder: RTL and testbench

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/imm_encoder_if.sv | 33 +++
 rtl/imm_encoder.sv | 167 ++++++++++++++++
 tb/tb_imm_encoder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/imm_encoder_if.sv
// rtl/imm_encoder_if.sv - request/result bundle for the immediate encoder
//
// Purpose : groups the start request, mode/value operands and the
//           busy/done/ok/Instr/up result signals of imm_encoder.
// Signals : start   1  request, sampled while the encoder is idle
//           ImmSrc  2  00 data-processing, 01 memory, 10 branch, 11 reserved
//           Value  32  immediate or byte offset to encode
//           busy    1  operation in progress (accepted start until done)
//           done    1  single-cycle completion pulse
//           ok      1  Value was encodable in the selected mode
//           Instr  24  encoded immediate field
//           up      1  memory offset add (1) / subtract (0)
// Modports: master drives the request, slave (the encoder) drives results.
interface imm_encoder_if;
    logic        start;
    logic [1:0]  ImmSrc;
    logic [31:0] Value;
    logic        busy;
    logic        done;
    logic        ok;
    logic [23:0] Instr;
    logic        up;

    modport master (
        output start, ImmSrc, Value,
        input  busy, done, ok, Instr, up
    );

    modport slave (
        input  start, ImmSrc, Value,
        output busy, done, ok, Instr, up
    );
endinterface

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - encodes a 32-bit value into a 24-bit immediate field
//
// Purpose : inverse of the Extend unit. Mode 00 searches the smallest even
//           left rotation that fits the value in 8 bits (one rotation per
//           cycle); modes 01/10/11 resolve in the accepting cycle.
// Ports   : clk    rising-edge clock
//           reset  asynchronous active-high reset
//           bus    imm_encoder_if.slave (start/ImmSrc/Value in,
//                  busy/done/ok/Instr/up out)
// Config  : IMM_ENC_NEG_EN - when defined, mode 01 also accepts offsets
//           -4095..-1 and reports them with up=0; when undefined up is
//           constant 1.
module imm_encoder (
    input  logic          clk,
    input  logic          reset,
    imm_encoder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t      state, stateNext;
    logic [3:0]  rot, rotNext;
    logic [1:0]  srcReg;
    logic [31:0] valueReg;
    logic        okReg, okNext;
    logic [23:0] instrReg, instrNext;

    // Results for the modes that resolve in the accepting cycle, taken
    // straight from the request inputs.
    logic        directOk;
    logic [23:0] directInstr;

    // Value rotated left by 2*rot; the doubled word makes rot=0 and the
    // modulo-32 wrap fall out without a special case.
    logic [63:0] dblShift;
    logic [31:0] rotated;
    assign dblShift = {valueReg, valueReg} << {rot, 1'b0};
    assign rotated  = dblShift[63:32];

`ifdef IMM_ENC_NEG_EN
    logic        upReg, upNext;
    logic        directUp;
    logic [31:0] negValue;
    assign negValue = -bus.Value;
`endif

    always_comb begin
        directOk    = 1'b0;
        directInstr = 24'h0;
`ifdef IMM_ENC_NEG_EN
        directUp    = 1'b1;
`endif
        case (bus.ImmSrc)
            2'b01: begin
                if (bus.Value < 32'd4096) begin
                    directOk    = 1'b1;
                    directInstr = {12'h0, bus.Value[11:0]};
                end
`ifdef IMM_ENC_NEG_EN
                else if (bus.Value[31] && negValue < 32'd4096) begin
                    directOk    = 1'b1;
                    directInstr = {12'h0, negValue[11:0]};
                    directUp    = 1'b0;
                end
`endif
            end
            2'b10: begin
                // word-aligned and representable as a signed 26-bit offset
                if (bus.Value[1:0] == 2'b00 &&
                    bus.Value[31:26] == {6{bus.Value[25]}}) begin
                    directOk    = 1'b1;
                    directInstr = bus.Value[25:2];
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        stateNext = state;
        rotNext   = rot;
        okNext    = okReg;
        instrNext = instrReg;
`ifdef IMM_ENC_NEG_EN
        upNext    = upReg;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.ImmSrc == 2'b00) begin
                        stateNext = SEARCH;
                        rotNext   = 4'd0;
                    end else begin
                        stateNext = DONE;
                        okNext    = directOk;
                        instrNext = directInstr;
`ifdef IMM_ENC_NEG_EN
                        upNext    = directUp;
`endif
                    end
                end
            end
            SEARCH: begin
                // only mode 00 enters SEARCH; anything else is unencodable
                if (srcReg == 2'b00 && rotated[31:8] == 24'h0) begin
                    stateNext = DONE;
                    okNext    = 1'b1;
                    instrNext = {12'h0, rot, rotated[7:0]};
`ifdef IMM_ENC_NEG_EN
                    upNext    = 1'b1;
`endif
                end else if (rot == 4'd15 || srcReg != 2'b00) begin
                    stateNext = DONE;
                    okNext    = 1'b0;
                    instrNext = 24'h0;
`ifdef IMM_ENC_NEG_EN
                    upNext    = 1'b1;
`endif
                end else begin
                    rotNext = rot + 4'd1;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rot      <= 4'd0;
            srcReg   <= 2'b00;
            valueReg <= 32'h0;
            okReg    <= 1'b0;
            instrReg <= 24'h0;
`ifdef IMM_ENC_NEG_EN
            upReg    <= 1'b1;
`endif
        end else begin
            state    <= stateNext;
            rot      <= rotNext;
            okReg    <= okNext;
            instrReg <= instrNext;
`ifdef IMM_ENC_NEG_EN
            upReg    <= upNext;
`endif
            if (state == IDLE && bus.start) begin
                srcReg   <= bus.ImmSrc;
                valueReg <= bus.Value;
            end
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.done  = (state == DONE);
    assign bus.ok    = okReg;
    assign bus.Instr = instrReg;
`ifdef IMM_ENC_NEG_EN
    assign bus.up    = upReg;
`else
    assign bus.up    = 1'b1;
`endif
endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - scoreboard bench for imm_encoder
module tb_imm_encoder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    imm_encoder_if bus();

    imm_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic        ok;
        logic [23:0] instr;
        logic        up;
        logic [31:0] lat;
    } exp_t;

    exp_t        sb[$];
    int          nChecks = 0;
    int          nFails  = 0;
    logic        prevOk;
    logic [23:0] prevInstr;
    logic        prevUp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] src, input logic [31:0] v);
        exp_t        e;
        logic [31:0] rv;
        bit          found;
        e.ok = 1'b0; e.instr = 24'h0; e.up = 1'b1; e.lat = 0;
        case (src)
            2'b00: begin
                e.lat = 16;
                found = 0;
                for (int r = 0; r < 16; r++) begin
                    rv = (r == 0) ? v : ((v << (2 * r)) | (v >> (32 - 2 * r)));
                    if (!found && rv[31:8] == 24'h0) begin
                        found   = 1;
                        e.ok    = 1'b1;
                        e.instr = {12'h0, 4'(r), rv[7:0]};
                        e.lat   = r + 1;
                    end
                end
            end
            2'b01: begin
                if (v < 4096) begin
                    e.ok = 1'b1;
                    e.instr = {12'h0, v[11:0]};
                end
`ifdef IMM_ENC_NEG_EN
                else if ($signed(v) >= -4095 && $signed(v) <= -1) begin
                    e.ok = 1'b1;
                    e.up = 1'b0;
                    e.instr = 24'(-$signed(v));
                end
`endif
            end
            2'b10: begin
                if (v[1:0] == 2'b00 && $signed(v) >= -33554432 && $signed(v) < 33554432) begin
                    e.ok = 1'b1;
                    e.instr = v[25:2];
                end
            end
            default: begin
            end
        endcase
        return e;
    endfunction

    task automatic runOp(input logic [1:0] src, input logic [31:0] v, input bit poke);
        exp_t e;
        int   lat;
        bit   seen;
        @(negedge clk);
        check("idle_busy", bus.busy, 0);
        check("idle_done", bus.done, 0);
        bus.start = 1'b1; bus.ImmSrc = src; bus.Value = v;
        sb.push_back(model(src, v));
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.ImmSrc = 2'b11; bus.Value = 32'hDEADBEEF;
        @(negedge clk);
        check("busy_after_E0", bus.busy, 1);
        lat = 0;
        seen = 0;
        while (!seen && lat <= 20) begin
            if (bus.done) begin
                seen = 1;
            end else begin
                if (lat == 0) begin
                    check("hold_ok", bus.ok, prevOk);
                    check("hold_instr", bus.Instr, prevInstr);
                    check("hold_up", bus.up, prevUp);
                end
                if (poke && lat == 2) begin
                    bus.start = 1'b1; bus.ImmSrc = 2'b01; bus.Value = 32'h5;
                end
                @(posedge clk);
                #1;
                bus.start = 1'b0; bus.ImmSrc = 2'b11; bus.Value = 32'hDEADBEEF;
                lat++;
                @(negedge clk);
            end
        end
        check("done_seen", seen, 1);
        e = sb.pop_front();
        if (seen) begin
            check("latency", lat, e.lat);
            check("ok", bus.ok, e.ok);
            check("instr", bus.Instr, e.instr);
            check("up", bus.up, e.up);
            check("busy_in_done", bus.busy, 1);
        end
        prevOk = e.ok; prevInstr = e.instr; prevUp = e.up;
    endtask

    initial begin
        int          pulses;
        logic [31:0] imm;
        int          s;
        bus.start = 1'b0; bus.ImmSrc = 2'b00; bus.Value = 32'h0;
        #12;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_ok", bus.ok, 0);
        check("rst_instr", bus.Instr, 0);
        check("rst_up", bus.up, 1);
        prevOk = 1'b0; prevInstr = 24'h0; prevUp = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        runOp(2'b00, 32'h000000FF, 0);
        runOp(2'b00, 32'hFF000000, 0);
        runOp(2'b00, 32'h00000101, 1);
        runOp(2'b00, 32'hC000003F, 0);
        runOp(2'b00, 32'h00000000, 0);
        runOp(2'b01, 32'h00000A93, 0);
        runOp(2'b01, 32'h00001000, 0);
        runOp(2'b01, 32'h00000FFF, 0);
        runOp(2'b01, 32'hFFFFFFF0, 0);
        runOp(2'b01, 32'hFFFFF001, 0);
        runOp(2'b10, 32'hFFFFFFF8, 0);
        runOp(2'b10, 32'h00000006, 0);
        runOp(2'b10, 32'h01FFFFFC, 0);
        runOp(2'b10, 32'h02000000, 0);
        runOp(2'b10, 32'hFE000000, 0);
        runOp(2'b11, 32'h00000004, 0);
        for (int i = 0; i < 6; i++) begin
            imm = $urandom_range(1, 255);
            s = 2 * $urandom_range(1, 15);
            runOp(2'b00, (imm >> s) | (imm << (32 - s)), 0);
            runOp(2'b00, $urandom, 0);
        end

        // reset while SEARCH is running
        @(negedge clk);
        bus.start = 1'b1; bus.ImmSrc = 2'b00; bus.Value = 32'h00000101;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_ok", bus.ok, 0);
        check("midrst_instr", bus.Instr, 0);
        check("midrst_up", bus.up, 1);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("no_done_after_reset", pulses, 0);
        prevOk = 1'b0; prevInstr = 24'h0; prevUp = 1'b1;
        runOp(2'b01, 32'h00000A93, 0);
        runOp(2'b00, 32'hFF000000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
